hashcam_arbiter: RTL and testbench
==================================

// Module: hashcam_arbiter
// PURPOSE
// Shares one HashCAM between a lookup requester (packet path) and an update
// requester (control path). Serialises transactions so the CAM never sees
// lookup_enable and write_enable high together (they share match/value_out),
// runs the CAM's level enable/ready handshake, captures results, and
// presents a clocked req/ack interface with a timeout guard.
// PARAMETERS
// KEY_WIDTH_IN_OCTETS  2     key width in octets (KW = 8*this)
// VALUE_WIDTH_IN_BITS  8     value width (VW)
// TIMEOUT_CYCLES       1024  max cycles in WAIT_RDY or RELEASE before abort
// ARB_MODE             0     0 = round-robin; 1 = update has strict priority
// PORTS
// clk                input   1   clock
// reset              input   1   asynchronous, active-high reset
// lkp_req            input   1   lookup request; held with lkp_key until lkp_ack
// lkp_key            input   KW  lookup key
// lkp_ack            output  1   1-cycle pulse: lookup done, results valid this cycle
// lkp_hit            output  1   key found
// lkp_value          output  VW  value if hit, else 0
// upd_req            input   1   update request; held with key/value until upd_ack
// upd_key            input   KW  key to insert/overwrite
// upd_value          output? no: input VW  value to write
// upd_ack            output  1   1-cycle pulse: update done
// upd_hit            output  1   key existed and was overwritten
// upd_old_value      output  VW  previous value if upd_hit, else 0
// upd_full           output  1   CAM full flag sampled at completion
// err_timeout        output  1   sticky: a transaction timed out
// cam_lookup_enable  output  1   to CAM lookup_enable
// cam_write_enable   output  1   to CAM write_enable
// cam_key            output  KW  to CAM key_in
// cam_value          output  VW  to CAM value_in
// cam_lookup_ready   input   1   from CAM; async, 2-flop synchronised
// cam_write_ready    input   1   from CAM; async, 2-flop synchronised
// cam_match          input   1   from CAM match
// cam_full           input   1   from CAM full (sticky in CAM)
// cam_value_out      input   VW  from CAM value_out
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, synchronisers 0, RR pointer = "update
//   last", so lookup wins the first tie. Reset mid-transaction drops both
//   enables immediately; no ack is issued for the aborted request.
// - All outputs registered. States: IDLE, SETUP, WAIT_RDY, RELEASE, DONE.
// - IDLE: pick requester (ARB_MODE rule); load cam_key (and cam_value for
//   update) from its inputs; record grant; -> SETUP. None pending: stay.
// - SETUP (1 cycle, key stable before enable edge): raise granted enable
//   only; -> WAIT_RDY; clear timeout counter.
// - WAIT_RDY: on synced ready=1: capture cam_match, cam_value_out, cam_full;
//   drop enable; -> RELEASE. Captured value forced 0 if cam_match=0.
// - RELEASE: wait synced ready=0 (CAM clears ready on enable fall);
//   -> DONE.
// - DONE: pulse granted ack 1 cycle with captured results; update RR
//   pointer; -> IDLE. Result outputs hold until next ack of that port.
// - Timeout: counter increments in WAIT_RDY/RELEASE; reaching TIMEOUT_CYCLES
//   drops enable, -> DONE with hit=0, value=0, upd_full=0; err_timeout<=1.
// - Requester protocol: req sampled only in IDLE; a req still high in the
//   cycle after ack is a new request. Inputs changing while req high before
//   ack are ignored (captured in IDLE).
// - Never both cam enables high; enable never re-raised before synced ready
//   seen low. Minimum req->ack: 5 cycles + CAM latency + 2x sync delay.
// - Round-robin: on tie, grant opposite of last completed grant.
// TESTING
// 1 After reset, lkp_key=0x1234 -> lkp_ack pulse, lkp_hit=0, lkp_value=0.
// 2 upd 0x1234/0xAB -> upd_hit=0, upd_full=0; then lookup 0x1234 -> hit=1,
//   lkp_value=0xAB.
// 3 upd 0x1234/0xCD -> upd_hit=1, upd_old_value=0xAB; lookup -> 0xCD.
// 4 lkp_req and upd_req same cycle, both held -> lookup acked first, then
//   update; checker: enables never both 1 on any cycle.
// 5 CAM model never raises ready, TIMEOUT_CYCLES=16 -> ack 16+ cycles after
//   enable, hit=0, err_timeout=1 held until reset.
// 6 reset pulse during WAIT_RDY -> enables 0 at once, no ack, IDLE; next
//   request completes normally.

Source files
------------

// File: rtl/hashcam_arbiter.sv
// hashcam_arbiter
// Serialises lookup and update transactions onto a single HashCAM. It drives
// the CAM's level enable/ready handshake, captures the results, and returns
// them on two independent req/ack ports. A timeout guards against a CAM that
// never answers. The CAM ready lines are asynchronous and are synchronised
// here with two flops each.
module hashcam_arbiter #(
    parameter int KEY_WIDTH_IN_OCTETS = 2,
    parameter int VALUE_WIDTH_IN_BITS = 8,
    parameter int TIMEOUT_CYCLES      = 1024,
    parameter int ARB_MODE            = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             lkp_req,
    input  logic [8*KEY_WIDTH_IN_OCTETS-1:0] lkp_key,
    output logic                             lkp_ack,
    output logic                             lkp_hit,
    output logic [VALUE_WIDTH_IN_BITS-1:0]   lkp_value,
    input  logic                             upd_req,
    input  logic [8*KEY_WIDTH_IN_OCTETS-1:0] upd_key,
    input  logic [VALUE_WIDTH_IN_BITS-1:0]   upd_value,
    output logic                             upd_ack,
    output logic                             upd_hit,
    output logic [VALUE_WIDTH_IN_BITS-1:0]   upd_old_value,
    output logic                             upd_full,
    output logic                             err_timeout,
    output logic                             cam_lookup_enable,
    output logic                             cam_write_enable,
    output logic [8*KEY_WIDTH_IN_OCTETS-1:0] cam_key,
    output logic [VALUE_WIDTH_IN_BITS-1:0]   cam_value,
    input  logic                             cam_lookup_ready,
    input  logic                             cam_write_ready,
    input  logic                             cam_match,
    input  logic                             cam_full,
    input  logic [VALUE_WIDTH_IN_BITS-1:0]   cam_value_out
);

    localparam int KW = 8 * KEY_WIDTH_IN_OCTETS;
    localparam int VW = VALUE_WIDTH_IN_BITS;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_RDY,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic            grant_upd_reg, grant_upd_next;   // 1 = update owns the CAM
    logic            last_upd_reg, last_upd_next;     // last completed grant was update
    logic [KW-1:0]   cam_key_reg, cam_key_next;
    logic [VW-1:0]   cam_value_reg, cam_value_next;
    logic            lk_en_reg, lk_en_next;
    logic            wr_en_reg, wr_en_next;
    logic [CW-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic            cap_hit_reg, cap_hit_next;
    logic [VW-1:0]   cap_value_reg, cap_value_next;
    logic            cap_full_reg, cap_full_next;
    logic            err_reg, err_next;
    logic            lkp_ack_reg, lkp_ack_next;
    logic            lkp_hit_reg, lkp_hit_next;
    logic [VW-1:0]   lkp_value_reg, lkp_value_next;
    logic            upd_ack_reg, upd_ack_next;
    logic            upd_hit_reg, upd_hit_next;
    logic [VW-1:0]   upd_old_reg, upd_old_next;
    logic            upd_full_reg, upd_full_next;
    logic [1:0]      lk_sync_reg, wr_sync_reg;

    logic            rdy_synced;
    logic            timeout_hit;
    logic            finish;
    logic            pick_upd;

    // Two-flop synchronisers for the CAM's asynchronous ready lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lk_sync_reg <= 2'b00;
            wr_sync_reg <= 2'b00;
        end else begin
            lk_sync_reg <= {lk_sync_reg[0], cam_lookup_ready};
            wr_sync_reg <= {wr_sync_reg[0], cam_write_ready};
        end
    end

    assign rdy_synced  = grant_upd_reg ? wr_sync_reg[1] : lk_sync_reg[1];
    assign timeout_hit = (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    // State and datapath registers; reset drops both enables immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_upd_reg <= 1'b0;
            last_upd_reg  <= 1'b1;   // lookup wins the first tie
            cam_key_reg   <= '0;
            cam_value_reg <= '0;
            lk_en_reg     <= 1'b0;
            wr_en_reg     <= 1'b0;
            tmo_cnt_reg   <= '0;
            cap_hit_reg   <= 1'b0;
            cap_value_reg <= '0;
            cap_full_reg  <= 1'b0;
            err_reg       <= 1'b0;
            lkp_ack_reg   <= 1'b0;
            lkp_hit_reg   <= 1'b0;
            lkp_value_reg <= '0;
            upd_ack_reg   <= 1'b0;
            upd_hit_reg   <= 1'b0;
            upd_old_reg   <= '0;
            upd_full_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_upd_reg <= grant_upd_next;
            last_upd_reg  <= last_upd_next;
            cam_key_reg   <= cam_key_next;
            cam_value_reg <= cam_value_next;
            lk_en_reg     <= lk_en_next;
            wr_en_reg     <= wr_en_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            cap_hit_reg   <= cap_hit_next;
            cap_value_reg <= cap_value_next;
            cap_full_reg  <= cap_full_next;
            err_reg       <= err_next;
            lkp_ack_reg   <= lkp_ack_next;
            lkp_hit_reg   <= lkp_hit_next;
            lkp_value_reg <= lkp_value_next;
            upd_ack_reg   <= upd_ack_next;
            upd_hit_reg   <= upd_hit_next;
            upd_old_reg   <= upd_old_next;
            upd_full_reg  <= upd_full_next;
        end
    end

    // Next-state and output logic; acks are raised on entry to DONE so the
    // pulse coincides with the DONE cycle and a held req is re-sampled after it
    always_comb begin
        state_next     = state_reg;
        grant_upd_next = grant_upd_reg;
        last_upd_next  = last_upd_reg;
        cam_key_next   = cam_key_reg;
        cam_value_next = cam_value_reg;
        lk_en_next     = lk_en_reg;
        wr_en_next     = wr_en_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        cap_hit_next   = cap_hit_reg;
        cap_value_next = cap_value_reg;
        cap_full_next  = cap_full_reg;
        err_next       = err_reg;
        lkp_ack_next   = 1'b0;
        lkp_hit_next   = lkp_hit_reg;
        lkp_value_next = lkp_value_reg;
        upd_ack_next   = 1'b0;
        upd_hit_next   = upd_hit_reg;
        upd_old_next   = upd_old_reg;
        upd_full_next  = upd_full_reg;
        finish         = 1'b0;
        pick_upd       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (lkp_req || upd_req) begin
                    if (ARB_MODE == 1)
                        pick_upd = upd_req;
                    else if (lkp_req && upd_req)
                        pick_upd = ~last_upd_reg;
                    else
                        pick_upd = upd_req;
                    grant_upd_next = pick_upd;
                    cam_key_next   = pick_upd ? upd_key : lkp_key;
                    cam_value_next = pick_upd ? upd_value : '0;
                    state_next     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // key has been stable for a cycle; now raise only the granted enable
                lk_en_next   = ~grant_upd_reg;
                wr_en_next   = grant_upd_reg;
                tmo_cnt_next = '0;
                state_next   = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (rdy_synced) begin
                    cap_hit_next   = cam_match;
                    cap_value_next = cam_match ? cam_value_out : '0;
                    cap_full_next  = cam_full;
                    lk_en_next     = 1'b0;
                    wr_en_next     = 1'b0;
                    tmo_cnt_next   = tmo_cnt_reg + CW'(1);
                    state_next     = ST_RELEASE;
                end else if (timeout_hit) begin
                    finish = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + CW'(1);
                end
            end
            ST_RELEASE: begin
                // wait for the CAM to clear ready so the next enable is a clean edge
                if (!rdy_synced) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    finish = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + CW'(1);
                end
            end
            ST_DONE: begin
                last_upd_next = grant_upd_reg;
                state_next    = ST_IDLE;
            end
            default: begin
                lk_en_next = 1'b0;
                wr_en_next = 1'b0;
                state_next = ST_IDLE;
            end
        endcase

        // an expired guard discards whatever was captured
        if (finish && timeout_hit && !(state_reg == ST_RELEASE && !rdy_synced)) begin
            cap_hit_next   = 1'b0;
            cap_value_next = '0;
            cap_full_next  = 1'b0;
            lk_en_next     = 1'b0;
            wr_en_next     = 1'b0;
            err_next       = 1'b1;
        end

        if (finish) begin
            state_next = ST_DONE;
            if (grant_upd_reg) begin
                upd_ack_next  = 1'b1;
                upd_hit_next  = cap_hit_next;
                upd_old_next  = cap_value_next;
                upd_full_next = cap_full_next;
            end else begin
                lkp_ack_next   = 1'b1;
                lkp_hit_next   = cap_hit_next;
                lkp_value_next = cap_value_next;
            end
        end
    end

    assign lkp_ack           = lkp_ack_reg;
    assign lkp_hit           = lkp_hit_reg;
    assign lkp_value         = lkp_value_reg;
    assign upd_ack           = upd_ack_reg;
    assign upd_hit           = upd_hit_reg;
    assign upd_old_value     = upd_old_reg;
    assign upd_full          = upd_full_reg;
    assign err_timeout       = err_reg;
    assign cam_lookup_enable = lk_en_reg;
    assign cam_write_enable  = wr_en_reg;
    assign cam_key           = cam_key_reg;
    assign cam_value         = cam_value_reg;

endmodule

// File: tb/tb_hashcam_arbiter.sv
// Testbench for hashcam_arbiter: a behavioural CAM stub answers the enables,
// and an associative-array reference predicts every result and grant order.
module tb_hashcam_arbiter;

    localparam int KW  = 16;
    localparam int VW  = 8;
    localparam int TMO = 16;
    localparam int CAP = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lkp_req = 1'b0, upd_req = 1'b0;
    logic [KW-1:0] lkp_key = '0, upd_key = '0;
    logic [VW-1:0] upd_value = '0;
    logic          lkp_ack, lkp_hit, upd_ack, upd_hit, upd_full, err_timeout;
    logic [VW-1:0] lkp_value, upd_old_value;
    logic          cam_lookup_enable, cam_write_enable;
    logic [KW-1:0] cam_key;
    logic [VW-1:0] cam_value;
    logic          cam_lookup_ready = 1'b0, cam_write_ready = 1'b0;
    logic          cam_match = 1'b0, cam_full = 1'b0;
    logic [VW-1:0] cam_value_out = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_rise_cyc = 0;
    bit cam_dead = 1'b0;
    bit last_upd = 1'b1;
    bit [7:0] ref_val [int];

    hashcam_arbiter #(
        .KEY_WIDTH_IN_OCTETS(2), .VALUE_WIDTH_IN_BITS(8),
        .TIMEOUT_CYCLES(TMO), .ARB_MODE(0)
    ) dut (
        .clk(clk), .reset(reset),
        .lkp_req(lkp_req), .lkp_key(lkp_key), .lkp_ack(lkp_ack),
        .lkp_hit(lkp_hit), .lkp_value(lkp_value),
        .upd_req(upd_req), .upd_key(upd_key), .upd_value(upd_value),
        .upd_ack(upd_ack), .upd_hit(upd_hit), .upd_old_value(upd_old_value),
        .upd_full(upd_full), .err_timeout(err_timeout),
        .cam_lookup_enable(cam_lookup_enable), .cam_write_enable(cam_write_enable),
        .cam_key(cam_key), .cam_value(cam_value),
        .cam_lookup_ready(cam_lookup_ready), .cam_write_ready(cam_write_ready),
        .cam_match(cam_match), .cam_full(cam_full), .cam_value_out(cam_value_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CAM stub: table of up to CAP entries, random answer latency, ready
    // cleared once the enable falls; garbage value_out on a miss
    logic [KW-1:0] tbl_key [CAP];
    logic [VW-1:0] tbl_val [CAP];
    int tbl_cnt = 0;
    int lat = 0;
    always @(posedge clk) begin
        int idx;
        idx = -1;
        for (int i = 0; i < tbl_cnt; i++) if (tbl_key[i] == cam_key) idx = i;
        if (!cam_lookup_enable && !cam_write_enable) begin
            cam_lookup_ready <= 1'b0;
            cam_write_ready  <= 1'b0;
            lat <= int'($urandom_range(0, 3));
        end else if (!cam_dead && !cam_lookup_ready && !cam_write_ready) begin
            if (lat != 0) lat <= lat - 1;
            else begin
                cam_match     <= (idx >= 0);
                cam_value_out <= (idx >= 0) ? tbl_val[idx] : VW'($urandom);
                if (cam_write_enable) begin
                    if (idx >= 0) tbl_val[idx] = cam_value;
                    else if (tbl_cnt < CAP) begin
                        tbl_key[tbl_cnt] = cam_key;
                        tbl_val[tbl_cnt] = cam_value;
                        tbl_cnt++;
                    end
                    cam_write_ready <= 1'b1;
                end else begin
                    cam_lookup_ready <= 1'b1;
                end
                cam_full <= (tbl_cnt >= CAP);
            end
        end
    end

    // Continuous monitors: mutual exclusion of enables, single-cycle acks
    logic prev_lkp_ack = 1'b0, prev_upd_ack = 1'b0, prev_lk_en = 1'b0;
    always @(negedge clk) begin
        chk("en_overlap", {31'b0, cam_lookup_enable & cam_write_enable}, 0);
        if (prev_lkp_ack) chk("lkp_ack_pulse", {31'b0, lkp_ack}, 0);
        if (prev_upd_ack) chk("upd_ack_pulse", {31'b0, upd_ack}, 0);
        if (cam_lookup_enable && !prev_lk_en) en_rise_cyc = cyc;
        prev_lkp_ack = lkp_ack;
        prev_upd_ack = upd_ack;
        prev_lk_en   = cam_lookup_enable;
    end

    function automatic void ref_lookup(input logic [KW-1:0] k, output logic h, output logic [VW-1:0] v);
        h = ref_val.exists(int'(k));
        v = h ? ref_val[int'(k)] : 8'h00;
    endfunction

    function automatic void ref_update(input logic [KW-1:0] k, input logic [VW-1:0] nv,
                                       output logic h, output logic [VW-1:0] old, output logic f);
        h   = ref_val.exists(int'(k));
        old = h ? ref_val[int'(k)] : 8'h00;
        if (h || ref_val.size() < CAP) ref_val[int'(k)] = nv;
        f = (ref_val.size() >= CAP);
    endfunction

    // One transaction round: lookup, update, or both raised together
    task automatic run_txn(input bit do_lkp, input bit do_upd, input logic [KW-1:0] lk,
                           input logic [KW-1:0] uk, input logic [VW-1:0] uv,
                           input bit exp_tmo, input string tag);
        bit lk_pend, up_pend, first_seen, exp_first_upd, both;
        logic eh, ef;
        logic [VW-1:0] ev;
        lk_pend = do_lkp;
        up_pend = do_upd;
        both = do_lkp && do_upd;
        first_seen = 1'b0;
        exp_first_upd = both ? !last_upd : do_upd;
        @(posedge clk); #1;
        lkp_req = do_lkp; lkp_key = lk;
        upd_req = do_upd; upd_key = uk; upd_value = uv;
        for (int i = 0; i < 400 && (lk_pend || up_pend); i++) begin
            @(negedge clk);
            if (i == 2 && !both) begin
                // granted inputs were captured already; later changes must not matter
                lkp_key = KW'($urandom); upd_key = KW'($urandom); upd_value = VW'($urandom);
            end
            if (lkp_ack && lk_pend) begin
                if (exp_tmo) begin eh = 1'b0; ev = '0; end
                else ref_lookup(lk, eh, ev);
                chk({tag, "_lkp_hit"}, {31'b0, lkp_hit}, {31'b0, eh});
                chk({tag, "_lkp_value"}, {24'b0, lkp_value}, {24'b0, ev});
                if (exp_tmo) chk({tag, "_tmo_latency"}, {31'b0, (cyc - en_rise_cyc) >= TMO}, 1);
                if (both && !first_seen) chk({tag, "_order"}, 0, {31'b0, exp_first_upd});
                first_seen = 1'b1;
                lk_pend = 1'b0;
                last_upd = 1'b0;
            end
            if (upd_ack && up_pend) begin
                if (exp_tmo) begin eh = 1'b0; ev = '0; ef = 1'b0; end
                else ref_update(uk, uv, eh, ev, ef);
                chk({tag, "_upd_hit"}, {31'b0, upd_hit}, {31'b0, eh});
                chk({tag, "_upd_old"}, {24'b0, upd_old_value}, {24'b0, ev});
                chk({tag, "_upd_full"}, {31'b0, upd_full}, {31'b0, ef});
                if (both && !first_seen) chk({tag, "_order"}, 1, {31'b0, exp_first_upd});
                first_seen = 1'b1;
                up_pend = 1'b0;
                last_upd = 1'b1;
            end
            @(posedge clk); #1;
            if (!lk_pend) lkp_req = 1'b0;
            if (!up_pend) upd_req = 1'b0;
        end
        chk({tag, "_completed"}, {30'b0, lk_pend, up_pend}, 0);
        lkp_req = 1'b0;
        upd_req = 1'b0;
    endtask

    initial begin
        bit ok;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lkp_ack", {31'b0, lkp_ack}, 0);
        chk("rst_upd_ack", {31'b0, upd_ack}, 0);
        chk("rst_enables", {30'b0, cam_lookup_enable, cam_write_enable}, 0);
        chk("rst_err", {31'b0, err_timeout}, 0);
        chk("rst_cam_key", {16'b0, cam_key}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Directed basics
        run_txn(1, 0, 16'h1234, 0, 0, 0, "t1_miss");
        run_txn(0, 1, 0, 16'h1234, 8'hAB, 0, "t2_insert");
        run_txn(1, 0, 16'h1234, 0, 0, 0, "t2_lookup");
        run_txn(0, 1, 0, 16'h1234, 8'hCD, 0, "t3_overwrite");
        run_txn(1, 0, 16'h1234, 0, 0, 0, "t3_lookup");
        run_txn(0, 1, 0, 16'h0042, 8'h11, 0, "t4_pre");
        run_txn(1, 1, 16'h1234, 16'h0042, 8'h22, 0, "t4_both");

        // Randomised mix over a small key space so hits and CAM-full occur
        for (int n = 0; n < 40; n++) begin
            int op;
            op = int'($urandom_range(0, 2));
            run_txn(op != 1, op != 0, KW'($urandom_range(0, 9)), KW'($urandom_range(0, 9)),
                    VW'($urandom), 0, "rand");
        end

        // Timeout: the CAM never answers
        cam_dead = 1'b1;
        run_txn(1, 0, 16'h1234, 0, 0, 1, "t5_timeout");
        @(negedge clk);
        chk("t5_err_set", {31'b0, err_timeout}, 1);
        chk("t5_enables_low", {30'b0, cam_lookup_enable, cam_write_enable}, 0);
        cam_dead = 1'b0;
        run_txn(1, 0, 16'h1234, 0, 0, 0, "t5_after");
        chk("t5_err_sticky", {31'b0, err_timeout}, 1);

        // Reset while waiting on ready
        cam_dead = 1'b1;
        @(posedge clk); #1 lkp_req = 1'b1; lkp_key = 16'h1234;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cam_lookup_enable) ok = 1'b1;
        end
        chk("t6_enable_seen", {31'b0, ok}, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_enables_drop", {30'b0, cam_lookup_enable, cam_write_enable}, 0);
        chk("t6_no_ack", {31'b0, lkp_ack}, 0);
        chk("t6_err_cleared", {31'b0, err_timeout}, 0);
        lkp_req = 1'b0;
        cam_dead = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        last_upd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_quiet_ack", {30'b0, lkp_ack, upd_ack}, 0);
        end
        run_txn(1, 0, 16'h1234, 0, 0, 0, "t6_recover_lkp");
        run_txn(1, 1, 16'h0042, 16'h0077, 8'h5A, 0, "t6_recover_both");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
